// File: rtl/mac_feeder_pkg.sv
// Shared constants and state encoding for the MAC operand feeder.
// The window length, sample width and result width are fixed by the external MAC.
package mac_feeder_pkg;

  localparam int TAPS = 5;
  localparam int DW   = 8;
  localparam int RW   = 16;

  localparam logic [2:0] COEF_ADDR_MAX = 3'd4;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // Plain constants for code that keeps the state in a logic vector
  localparam logic [1:0] S_FILL = 2'(ST_FILL);
  localparam logic [1:0] S_RUN  = 2'(ST_RUN);
  localparam logic [1:0] S_WAIT = 2'(ST_WAIT);
  localparam logic [1:0] S_HOLD = 2'(ST_HOLD);

endpackage

// File: rtl/mac_feeder_if.sv
// Valid/ready stream bundle used for both the sample input and the result output.
// The width is set per instance: DW for samples, RW for MAC results.
interface mac_feeder_if #(
  parameter int W = 8
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/mac_feeder.sv
// Keeps a 5-tap sample window and coefficient set registered in front of an external
// MAC, then waits MAC_LAT cycles and presents the MAC sum on a valid/ready output.
module mac_feeder
  import mac_feeder_pkg::*;
#(
  parameter int MAC_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  mac_feeder_if.slave         s,
  mac_feeder_if.master        m,
  input  logic                coef_we,
  input  logic [2:0]          coef_addr,
  input  logic [DW-1:0]       coef_data,
  output logic                coef_err,
  input  logic                flush,
  output logic [DW-1:0]       mac_a1,
  output logic [DW-1:0]       mac_a2,
  output logic [DW-1:0]       mac_a3,
  output logic [DW-1:0]       mac_a4,
  output logic [DW-1:0]       mac_a5,
  output logic [DW-1:0]       mac_c1,
  output logic [DW-1:0]       mac_c2,
  output logic [DW-1:0]       mac_c3,
  output logic [DW-1:0]       mac_c4,
  output logic [DW-1:0]       mac_c5,
  input  logic [RW-1:0]       mac_result
);

  logic [1:0]    state;
  logic [2:0]    fill_cnt;
  logic [2:0]    lat_cnt;
  logic [DW-1:0] win  [TAPS];
  logic [DW-1:0] coef [TAPS];
  logic [RW-1:0] m_data_q;
  logic          m_valid_q;

  logic open_st;
  logic accept;
  logic coef_ok;

  // Samples and coefficient writes are only taken while the operands are not in flight
  assign open_st = (state == S_FILL) || (state == S_RUN);
  assign accept  = s.valid && s.ready;
  assign coef_ok = open_st && (coef_addr <= COEF_ADDR_MAX);

  assign s.ready = rst_n && open_st;
  assign m.valid = m_valid_q;
  assign m.data  = m_data_q;

  assign mac_a1 = win[0];
  assign mac_a2 = win[1];
  assign mac_a3 = win[2];
  assign mac_a4 = win[3];
  assign mac_a5 = win[4];
  assign mac_c1 = coef[0];
  assign mac_c2 = coef[1];
  assign mac_c3 = coef[2];
  assign mac_c4 = coef[3];
  assign mac_c5 = coef[4];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_FILL;
      fill_cnt  <= '0;
      lat_cnt   <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      coef_err  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        win[i]  <= '0;
        coef[i] <= '0;
      end
    end else if (flush) begin
      // Coefficients survive a flush; any pending or held result is abandoned
      state     <= S_FILL;
      fill_cnt  <= '0;
      lat_cnt   <= '0;
      m_valid_q <= 1'b0;
      coef_err  <= 1'b0;
      for (int i = 0; i < TAPS; i++) win[i] <= '0;
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_we && coef_ok) coef[coef_addr] <= coef_data;

      if (accept) begin
        for (int i = TAPS - 1; i > 0; i--) win[i] <= win[i-1];
        win[0] <= s.data;
      end

      case (state)
        S_FILL: begin
          if (accept) begin
            fill_cnt <= fill_cnt + 3'd1;
            if (fill_cnt == 3'(TAPS - 1)) begin
              state   <= S_WAIT;
              lat_cnt <= 3'(MAC_LAT);
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            state   <= S_WAIT;
            lat_cnt <= 3'(MAC_LAT);
          end
        end
        S_WAIT: begin
          if (lat_cnt == 3'd0) begin
            m_data_q  <= mac_result;
            m_valid_q <= 1'b1;
            state     <= S_HOLD;
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        S_HOLD: begin
          if (m.ready) begin
            m_valid_q <= 1'b0;
            state     <= S_RUN;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder with a behavioural MAC and a cycle-level reference model.
// Directed scenarios pin literal results, then randomized traffic runs against the model.
module tb_mac_feeder;
  import mac_feeder_pkg::*;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_feeder_if #(.W(DW)) s_if ();
  mac_feeder_if #(.W(RW)) m_if ();

  logic          coef_we;
  logic [2:0]    coef_addr;
  logic [DW-1:0] coef_data;
  logic          coef_err;
  logic          flush;
  logic [DW-1:0] mac_a1, mac_a2, mac_a3, mac_a4, mac_a5;
  logic [DW-1:0] mac_c1, mac_c2, mac_c3, mac_c4, mac_c5;
  logic [RW-1:0] mac_result;

  mac_feeder #(.MAC_LAT(LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s_if),
    .m          (m_if),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .coef_err   (coef_err),
    .flush      (flush),
    .mac_a1     (mac_a1),
    .mac_a2     (mac_a2),
    .mac_a3     (mac_a3),
    .mac_a4     (mac_a4),
    .mac_a5     (mac_a5),
    .mac_c1     (mac_c1),
    .mac_c2     (mac_c2),
    .mac_c3     (mac_c3),
    .mac_c4     (mac_c4),
    .mac_c5     (mac_c5),
    .mac_result (mac_result)
  );

  // External MAC: sum of products, LAT register stages, wraps to RW bits
  function automatic int prod(input logic [7:0] a, input logic [7:0] c);
    return int'(a) * int'(c);
  endfunction

  logic [RW-1:0] mac_pipe [LAT];
  always @(posedge clk) begin
    mac_pipe[0] <= RW'(prod(mac_a1, mac_c1) + prod(mac_a2, mac_c2) + prod(mac_a3, mac_c3)
                       + prod(mac_a4, mac_c4) + prod(mac_a5, mac_c5));
    for (int i = 1; i < LAT; i++) mac_pipe[i] <= mac_pipe[i-1];
  end
  assign mac_result = mac_pipe[LAT-1];

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: window/coefficients as arrays, result timing by absolute cycle number
  int            cyc = 0;
  int            e_win  [5];
  int            e_coef [5];
  int            e_cnt = 0;
  int            e_due = 0;
  bit            e_pend = 0;
  bit            e_hold = 0;
  bit            e_mvalid = 0;
  bit            e_err = 0;
  logic [RW-1:0] e_sum = '0;
  logic [RW-1:0] e_mdata = '0;

  initial begin
    for (int i = 0; i < 5; i++) begin
      e_win[i]  = 0;
      e_coef[i] = 0;
    end
  end

  always @(posedge clk) begin : model
    bit busy;
    int acc;
    cyc++;
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) begin
        e_win[i]  = 0;
        e_coef[i] = 0;
      end
      e_cnt = 0; e_pend = 0; e_hold = 0; e_mvalid = 0; e_err = 0; e_mdata = '0;
    end else if (flush) begin
      for (int i = 0; i < 5; i++) e_win[i] = 0;
      e_cnt = 0; e_pend = 0; e_hold = 0; e_mvalid = 0; e_err = 0;
    end else begin
      busy  = e_pend || e_hold;
      e_err = coef_we && (busy || coef_addr > 3'd4);
      if (coef_we && !e_err) e_coef[coef_addr] = int'(coef_data);
      if (e_hold && m_if.ready) begin
        e_hold = 0;
        e_mvalid = 0;
      end
      if (e_pend && cyc == e_due) begin
        e_pend = 0; e_hold = 1; e_mvalid = 1; e_mdata = e_sum;
      end
      if (s_if.valid && !busy) begin
        for (int i = 4; i > 0; i--) e_win[i] = e_win[i-1];
        e_win[0] = int'(s_if.data);
        if (e_cnt < 5) e_cnt++;
        if (e_cnt == 5) begin
          acc = 0;
          for (int i = 0; i < 5; i++) acc += e_win[i] * e_coef[i];
          e_sum  = RW'(acc);
          e_pend = 1;
          e_due  = cyc + LAT + 1;
        end
      end
    end
  end

  always @(posedge clk) begin : compare
    #1;
    chk("s_ready", s_if.ready, rst_n && !(e_pend || e_hold));
    chk("m_valid", m_if.valid, e_mvalid);
    chk("m_data", m_if.data, e_mdata);
    chk("coef_err", coef_err, e_err);
    chk("mac_a", {mac_a1, mac_a2, mac_a3, mac_a4, mac_a5},
        {8'(e_win[0]), 8'(e_win[1]), 8'(e_win[2]), 8'(e_win[3]), 8'(e_win[4])});
    chk("mac_c", {mac_c1, mac_c2, mac_c3, mac_c4, mac_c5},
        {8'(e_coef[0]), 8'(e_coef[1]), 8'(e_coef[2]), 8'(e_coef[3]), 8'(e_coef[4])});
  end

  task automatic push(input logic [7:0] d);
    int n = 0;
    s_if.data  = d;
    s_if.valid = 1'b1;
    while (!s_if.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      vecs++;
      errs++;
      $display("FAIL push_timeout: s_ready stuck at %0b, required 1", s_if.ready);
    end
    @(negedge clk);
    s_if.valid = 1'b0;
  endtask

  task automatic wcoef(input logic [2:0] a, input logic [7:0] d);
    coef_we = 1'b1; coef_addr = a; coef_data = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic wait_mvalid(output int n);
    n = 0;
    while (!m_if.valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    s_if.valid = 1'b0; s_if.data = '0; m_if.ready = 1'b1;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; flush = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_s_ready", s_if.ready, 1'b0);
    chk("rst_m_valid", m_if.valid, 1'b0);
    chk("rst_mac_a1", mac_a1, 8'd0);
    rst_n = 1'b1;

    // unit coefficients, samples 1..5
    for (int i = 0; i < 5; i++) wcoef(3'(i), 8'd1);
    for (int d = 1; d <= 5; d++) push(8'(d));
    wait_mvalid(n);
    chk("lat_unit", n, LAT + 1);
    chk("sum_unit", m_if.data, 16'd15);
    @(negedge clk);
    chk("unit_single_pulse", m_if.valid, 1'b0);

    // ramp coefficients, then a sliding sample
    for (int i = 0; i < 5; i++) wcoef(3'(i), 8'(i + 1));
    do_flush();
    for (int d = 1; d <= 5; d++) push(8'(d));
    wait_mvalid(n);
    chk("sum_ramp", m_if.data, 16'd35);
    @(negedge clk);
    push(8'd6);
    wait_mvalid(n);
    chk("lat_run", n, LAT + 1);
    chk("sum_slide", m_if.data, 16'd50);
    @(negedge clk);

    // downstream stall
    m_if.ready = 1'b0;
    push(8'd7);
    wait_mvalid(n);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_valid", m_if.valid, 1'b1);
      chk("hold_data", m_if.data, 16'd65);
      chk("hold_s_ready", s_if.ready, 1'b0);
    end
    m_if.ready = 1'b1;
    @(negedge clk);
    chk("release_valid", m_if.valid, 1'b0);
    chk("release_s_ready", s_if.ready, 1'b1);

    // rejected coefficient writes
    wcoef(3'd6, 8'd77);
    chk("err_addr", coef_err, 1'b1);
    chk("coef_kept", {mac_c1, mac_c2, mac_c3, mac_c4, mac_c5}, 40'h0102030405);
    @(negedge clk);
    chk("err_one_cycle", coef_err, 1'b0);
    push(8'd8);
    wcoef(3'd0, 8'd99);
    chk("err_wait", coef_err, 1'b1);
    chk("coef_kept_wait", mac_c1, 8'd1);
    wait_mvalid(n);
    chk("sum_after_err", m_if.data, 16'd80);
    @(negedge clk);

    // flush colliding with a sample
    do_flush();
    for (int d = 1; d <= 3; d++) push(8'(d));
    s_if.data = 8'd9; s_if.valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; s_if.valid = 1'b0;
    chk("flush_drop", mac_a1, 8'd0);
    for (int d = 1; d <= 4; d++) push(8'(d));
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      chk("flush_no_result", m_if.valid, 1'b0);
    end
    push(8'd5);
    wait_mvalid(n);
    chk("flush_lat", n, LAT + 1);
    chk("flush_sum", m_if.data, 16'd35);
    @(negedge clk);

    // reset while waiting on the MAC
    push(8'd9);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_s_ready", s_if.ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_a", {mac_a1, mac_a2, mac_a3, mac_a4, mac_a5}, 40'd0);
    chk("rst_mid_c", {mac_c1, mac_c2, mac_c3, mac_c4, mac_c5}, 40'd0);
    chk("rst_mid_mdata", m_if.data, 16'd0);
    chk("rst_mid_err", coef_err, 1'b0);
    for (int k = 0; k < LAT + 3; k++) begin
      @(negedge clk);
      chk("rst_mid_no_valid", m_if.valid, 1'b0);
    end

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      s_if.valid = ($urandom_range(0, 9) < 7);
      s_if.data  = 8'($urandom);
      coef_we    = ($urandom_range(0, 9) == 0);
      coef_addr  = 3'($urandom_range(0, 7));
      coef_data  = 8'($urandom);
      flush      = ($urandom_range(0, 59) == 0);
      m_if.ready = ($urandom_range(0, 2) != 0);
      rst_n      = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    s_if.valid = 1'b0; coef_we = 1'b0; flush = 1'b0; rst_n = 1'b1; m_if.ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
